// File: rtl/instruction_cache_pkg.sv
// Shared types and address-geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    UPDATE
  } state_e;

  function automatic int unsigned offset_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned index_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned line_words,
                                        input int unsigned num_lines);
    return addr_w - 2 - offset_w(line_words) - index_w(num_lines);
  endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side lookup and instruction-memory fill signals of the instruction cache.
interface instruction_cache_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0] pc_addr;
  logic              pc_valid;
  logic              flush;
  logic [31:0]       instruction;
  logic              hit;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output pc_addr, pc_valid, flush, mem_ack, mem_rdata,
    input  instruction, hit, mem_req, mem_addr
  );

  modport slave (
    input  pc_addr, pc_valid, flush, mem_ack, mem_rdata,
    output instruction, hit, mem_req, mem_addr
  );

endinterface

// File: rtl/instruction_cache_line_store.sv
// Tag, valid and data arrays: combinational read, one-word data write, tag/valid write, flush-all.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned TAG_W      = 26,
  localparam int unsigned OFFSET_W  = offset_w(LINE_WORDS),
  localparam int unsigned INDEX_W   = index_w(NUM_LINES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [31:0]         rd_word,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [31:0]         wr_data,
  input  logic                tag_wr_en,
  input  logic [INDEX_W-1:0]  tag_wr_index,
  input  logic [TAG_W-1:0]    tag_wr_tag,
  input  logic                flush_all
);

  logic [31:0]          data_q  [NUM_LINES][LINE_WORDS];
  logic [31:0]          data_d  [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     tag_q   [NUM_LINES];
  logic [TAG_W-1:0]     tag_d   [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;

  assign rd_word  = data_q[rd_index][rd_offset];
  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (wr_en) begin
      data_d[wr_index][wr_offset] = wr_data;
    end
    if (tag_wr_en) begin
      tag_d[tag_wr_index]   = tag_wr_tag;
      valid_d[tag_wr_index] = 1'b1;
    end
    // Flush outranks a same-cycle tag write so a half-built line never becomes valid.
    if (flush_all) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with line-fill FSM.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_cache_if.slave   bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int unsigned OFFSET_W = offset_w(LINE_WORDS);
  localparam int unsigned INDEX_W  = index_w(NUM_LINES);
  localparam int unsigned TAG_W    = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int unsigned BASE_W   = TAG_W + INDEX_W;

  logic [OFFSET_W-1:0] pc_offset;
  logic [INDEX_W-1:0]  pc_index;
  logic [TAG_W-1:0]    pc_tag;
  logic                unused_addr_bits;

  assign pc_offset        = bus.pc_addr[OFFSET_W+1:2];
  assign pc_index         = bus.pc_addr[OFFSET_W+2 +: INDEX_W];
  assign pc_tag           = bus.pc_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^bus.pc_addr[1:0];

  state_e              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d, cnt_next;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic [31:0]         rd_word;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                hit;

  icache_line_store #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk          (clk),
    .reset        (reset),
    .rd_index     (pc_index),
    .rd_offset    (pc_offset),
    .rd_word      (rd_word),
    .rd_tag       (rd_tag),
    .rd_valid     (rd_valid),
    .wr_en        (state_q == FILL && bus.mem_ack && !bus.flush),
    .wr_index     (base_q[INDEX_W-1:0]),
    .wr_offset    (cnt_q),
    .wr_data      (bus.mem_rdata),
    .tag_wr_en    (state_q == UPDATE && !bus.flush),
    .tag_wr_index (base_q[INDEX_W-1:0]),
    .tag_wr_tag   (base_q[BASE_W-1 -: TAG_W]),
    .flush_all    (bus.flush)
  );

  assign hit = bus.pc_valid && state_q == IDLE && rd_valid && rd_tag == pc_tag &&
               !bus.flush && !reset;

  assign bus.hit         = hit;
  assign bus.instruction = rd_word;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;

  assign cnt_next = cnt_q + OFFSET_W'(1);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.pc_valid && !hit && !bus.flush) begin
          base_d     = {pc_tag, pc_index};
          cnt_d      = '0;
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_tag, pc_index, {OFFSET_W{1'b0}}, 2'b00};
        end
      end
      FILL: begin
        if (bus.flush) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (bus.mem_ack) begin
          if (cnt_q == OFFSET_W'(LINE_WORDS - 1)) begin
            state_d   = UPDATE;
            mem_req_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d      = cnt_next;
            mem_addr_d = {base_q, cnt_next, 2'b00};
          end
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && hit_count_q != '1) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (state_q == IDLE && state_d == FILL && miss_count_q != '1) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
